vmcmp_seq: RTL and testbench



---
 rtl/vmcmp_seq_pkg.sv | 11 +
 rtl/vmcmp_seq_meta_pipe.sv | 31 +++
 rtl/vmcmp_seq.sv | 140 ++++++++++++++
 tb/tb_vmcmp_seq.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vmcmp_seq_pkg.sv
// vmcmp_seq_pkg: shared vector-unit types (SEW codes, compare ops, sequencer states) and elements-per-beat helper
package vmcmp_seq_pkg;
  typedef enum logic [2:0] {SEW8, SEW16, SEW32, SEW64} sew_e;
  typedef enum logic [2:0] {OP_EQ, OP_NE, OP_LTU, OP_LT, OP_LEU, OP_LE, OP_GTU, OP_GT} opsel_e;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_e;
  function automatic int epb(int dw, logic [2:0] sew);
    int e;
    e = (dw / 8) >> sew;
    return e < 1 ? 1 : e;
  endfunction
endpackage

// File: rtl/vmcmp_seq_meta_pipe.sv
// vmcmp_seq_meta_pipe: DEPTH-stage shift of {valid,start_idx,first,last,addr}; in_* captured each cycle, out_* after DEPTH cycles, zero when invalid
module vmcmp_seq_meta_pipe
  import vmcmp_seq_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_idx,
  input  logic          in_first,
  input  logic          in_last,
  input  logic [AW-1:0] in_addr,
  output logic          out_valid,
  output logic [7:0]    out_idx,
  output logic          out_first,
  output logic          out_last,
  output logic [AW-1:0] out_addr
);
  localparam int W = AW + 11;
  logic [W-1:0] sr [DEPTH];
  always_ff @(posedge clk)
    if (!rst)
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    else begin
      sr[0] <= in_valid ? {1'b1, in_idx, in_first, in_last, in_addr} : '0;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  assign {out_valid, out_idx, out_first, out_last, out_addr} = sr[DEPTH-1];
endmodule

// File: rtl/vmcmp_seq.sv
// vmcmp_seq: mask-compare sequencer; cmd_* handshake in, paired rd_* register-file reads, cmp_* beats to compare unit, busy/done status
module vmcmp_seq
  import vmcmp_seq_pkg::*;
#(
  parameter int REQ_DATA_WIDTH = 64,
  parameter int REQ_ADDR_WIDTH = 32,
  parameter int OPSEL_WIDTH = 3,
  parameter int VL_WIDTH = 9,
  parameter int RD_LAT = 1,
  parameter int CMP_LAT = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [REQ_ADDR_WIDTH-1:0] cmd_vs2,
  input  logic [REQ_ADDR_WIDTH-1:0] cmd_vs1,
  input  logic [REQ_ADDR_WIDTH-1:0] cmd_vd,
  input  logic [2:0]                cmd_sew,
  input  logic [VL_WIDTH-1:0]       cmd_vl,
  input  logic [OPSEL_WIDTH-1:0]    cmd_opsel,
  output logic                      rd_req,
  input  logic                      rd_gnt,
  output logic [REQ_ADDR_WIDTH-1:0] rd_addr0,
  output logic [REQ_ADDR_WIDTH-1:0] rd_addr1,
  input  logic [REQ_DATA_WIDTH-1:0] rd_data0,
  input  logic [REQ_DATA_WIDTH-1:0] rd_data1,
  output logic                      cmp_valid,
  output logic [REQ_DATA_WIDTH-1:0] cmp_vec0,
  output logic [REQ_DATA_WIDTH-1:0] cmp_vec1,
  output logic [2:0]                cmp_sew,
  output logic [OPSEL_WIDTH-1:0]    cmp_opsel,
  output logic [7:0]                cmp_start_idx,
  output logic                      cmp_req_start,
  output logic                      cmp_req_end,
  output logic [REQ_ADDR_WIDTH-1:0] cmp_addr,
  output logic                      busy,
  output logic                      done
);
  localparam int AW = REQ_ADDR_WIDTH;
  localparam int VW = VL_WIDTH;
  localparam int EW = VL_WIDTH + 3;
  localparam int LGB = $clog2(REQ_DATA_WIDTH / 8);
  localparam int CW = $clog2(CMP_LAT + 2);
  state_e state;
  logic [AW-1:0] vs2_q, vs1_q, vd_q;
  logic [2:0] sew_q;
  logic [OPSEL_WIDTH-1:0] op_q;
  logic [VW-1:0] beats_q, beat_q, beats_n;
  logic [EW-1:0] elem_q, epb_q;
  logic [CW-1:0] cnt_q;
  logic [VW:0] vl_rnd;
  int lg;
  logic gnt, last_beat;
  logic m_valid, m_first, m_last;
  logic [7:0] m_idx;
  logic [AW-1:0] m_addr;
  // EPB is a power of two, so ceil(vl/EPB) is a round-up add and a shift
  always_comb begin
    lg = int'(cmd_sew) > LGB ? 0 : LGB - int'(cmd_sew);
    vl_rnd = {1'b0, cmd_vl} + (VW+1)'(epb(REQ_DATA_WIDTH, cmd_sew) - 1);
    beats_n = VW'(vl_rnd >> lg);
  end
  assign rd_req = state == S_ISSUE;
  assign gnt = rd_req & rd_gnt;
  assign last_beat = beat_q == beats_q - 1'b1;
  assign rd_addr0 = rd_req ? vs2_q + AW'(beat_q) : '0;
  assign rd_addr1 = rd_req ? vs1_q + AW'(beat_q) : '0;
  assign cmd_ready = state == S_IDLE;
  assign busy = !cmd_ready;
  assign done = state == S_DRAIN && cnt_q == '0;
  assign cmp_valid = m_valid;
  assign cmp_vec0 = m_valid ? rd_data0 : '0;
  assign cmp_vec1 = m_valid ? rd_data1 : '0;
  assign cmp_sew = m_valid ? sew_q : '0;
  assign cmp_opsel = m_valid ? op_q : '0;
  assign cmp_start_idx = m_idx;
  assign cmp_req_start = m_first;
  assign cmp_req_end = m_last;
  assign cmp_addr = m_addr;
  vmcmp_seq_meta_pipe #(.DEPTH(RD_LAT), .AW(AW)) u_meta (
    .clk(clk),
    .rst(rst),
    .in_valid(gnt),
    .in_idx({2'b0, elem_q[5:0]}),
    .in_first(beat_q == '0),
    .in_last(last_beat),
    .in_addr(vd_q + AW'(elem_q >> 6)),
    .out_valid(m_valid),
    .out_idx(m_idx),
    .out_first(m_first),
    .out_last(m_last),
    .out_addr(m_addr)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      state <= S_IDLE;
      vs2_q <= '0;
      vs1_q <= '0;
      vd_q <= '0;
      sew_q <= '0;
      op_q <= '0;
      beats_q <= '0;
      beat_q <= '0;
      elem_q <= '0;
      epb_q <= '0;
      cnt_q <= '0;
    end else
      case (state)
        S_IDLE:
          if (cmd_valid) begin
            vs2_q <= cmd_vs2;
            vs1_q <= cmd_vs1;
            vd_q <= cmd_vd;
            sew_q <= cmd_sew;
            op_q <= cmd_opsel;
            beats_q <= beats_n;
            beat_q <= '0;
            elem_q <= '0;
            epb_q <= EW'(epb(REQ_DATA_WIDTH, cmd_sew));
            cnt_q <= '0;
            state <= cmd_vl == '0 ? S_DRAIN : S_ISSUE;
          end
        S_ISSUE:
          if (gnt) begin
            beat_q <= beat_q + 1'b1;
            elem_q <= elem_q + epb_q;
            if (last_beat) state <= S_WAIT;
          end
        S_WAIT:
          if (m_valid && m_last) begin
            cnt_q <= CW'(CMP_LAT);
            state <= S_DRAIN;
          end
        S_DRAIN:
          if (cnt_q == '0) state <= S_IDLE;
          else cnt_q <= cnt_q - 1'b1;
        default: state <= S_IDLE;
      endcase
endmodule

// File: tb/tb_vmcmp_seq.sv
// tb_vmcmp_seq: directed self-checking bench for vmcmp_seq with RD_LAT=1 (u[0]) and RD_LAT=2 (u[1]) instances
module tb_vmcmp_seq;
  import vmcmp_seq_pkg::*;
  typedef struct packed {
    logic [7:0] idx;
    logic first, last;
    logic [31:0] addr;
    logic [63:0] v0, v1;
    logic [2:0] sew, op;
    int c;
  } beat_t;
  logic clk = 0, rst = 0, cmd_valid = 0, rd_gnt = 1;
  logic [31:0] cmd_vs2 = 0, cmd_vs1 = 0, cmd_vd = 0;
  logic [2:0] cmd_sew = 0, cmd_opsel = 0;
  logic [8:0] cmd_vl = 0;
  logic cmd_ready [2], rd_req [2], cmp_valid [2], cmp_req_start [2], cmp_req_end [2], busy [2], done [2];
  logic [31:0] rd_addr0 [2], rd_addr1 [2], cmp_addr [2];
  logic [63:0] rd_data0 [2], rd_data1 [2], cmp_vec0 [2], cmp_vec1 [2];
  logic [2:0] cmp_sew [2], cmp_opsel [2];
  logic [7:0] cmp_start_idx [2];
  beat_t bq[$];
  logic [31:0] aq0[$], aq1[$];
  logic [31:0] alog [16];
  logic [15:0] gpat = 16'hFFFF;
  int cyc = 0, sel = 0, acc_cyc = 1000000, first_rd = -1, first_cmp = -1, last_cmp = 0;
  int done_cyc = 0, done_cnt = 0, rdreq_cnt = 0, checks = 0, failures = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [63:0] f(input logic [31:0] a);
    return {a ^ 32'hC0DE_0000, a};
  endfunction
  for (genvar g = 0; g < 2; g++) begin : u
    logic [63:0] p0 [2], p1 [2];
    vmcmp_seq #(.RD_LAT(g + 1)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[g]),
      .cmd_vs2(cmd_vs2), .cmd_vs1(cmd_vs1), .cmd_vd(cmd_vd), .cmd_sew(cmd_sew),
      .cmd_vl(cmd_vl), .cmd_opsel(cmd_opsel), .rd_req(rd_req[g]), .rd_gnt(rd_gnt),
      .rd_addr0(rd_addr0[g]), .rd_addr1(rd_addr1[g]), .rd_data0(rd_data0[g]), .rd_data1(rd_data1[g]),
      .cmp_valid(cmp_valid[g]), .cmp_vec0(cmp_vec0[g]), .cmp_vec1(cmp_vec1[g]), .cmp_sew(cmp_sew[g]),
      .cmp_opsel(cmp_opsel[g]), .cmp_start_idx(cmp_start_idx[g]), .cmp_req_start(cmp_req_start[g]),
      .cmp_req_end(cmp_req_end[g]), .cmp_addr(cmp_addr[g]), .busy(busy[g]), .done(done[g])
    );
    always @(posedge clk) begin
      p0[0] <= (rd_req[g] && rd_gnt) ? f(rd_addr0[g]) : '0;
      p1[0] <= (rd_req[g] && rd_gnt) ? f(rd_addr1[g]) : '0;
      p0[1] <= p0[0];
      p1[1] <= p1[0];
    end
    assign rd_data0[g] = p0[g];
    assign rd_data1[g] = p1[g];
  end
  always @(negedge clk) begin
    int o;
    o = cyc - acc_cyc;
    if (rd_req[sel]) begin
      rdreq_cnt++;
      if (first_rd < 0) first_rd = cyc;
      if (o >= 0 && o < 16) alog[o] = rd_addr0[sel];
      if (rd_gnt) begin
        aq0.push_back(rd_addr0[sel]);
        aq1.push_back(rd_addr1[sel]);
      end
    end
    if (cmp_valid[sel]) begin
      bq.push_back('{cmp_start_idx[sel], cmp_req_start[sel], cmp_req_end[sel], cmp_addr[sel],
                     cmp_vec0[sel], cmp_vec1[sel], cmp_sew[sel], cmp_opsel[sel], cyc});
      last_cmp = cyc;
      if (first_cmp < 0) first_cmp = cyc;
    end
    if (done[sel]) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end
  task automatic run_cmd(input int k, input logic [31:0] a2, a1, ad, input logic [2:0] s,
                         input logic [8:0] l, input logic [2:0] op);
    int n = 0;
    sel = k;
    while (!(cmd_ready[0] && cmd_ready[1]) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    bq.delete(); aq0.delete(); aq1.delete();
    for (int i = 0; i < 16; i++) alog[i] = '0;
    done_cnt = 0; rdreq_cnt = 0; first_rd = -1; first_cmp = -1;
    cmd_vs2 = a2; cmd_vs1 = a1; cmd_vd = ad; cmd_sew = s; cmd_vl = l; cmd_opsel = op;
    cmd_valid = 1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    cmd_valid = 0;
    rd_gnt = gpat[0];
    n = 0;
    while (done_cnt == 0 && n < 300) begin
      @(posedge clk); #1;
      rd_gnt = (cyc - acc_cyc) < 16 ? gpat[cyc - acc_cyc] : 1'b1;
      n++;
    end
    rd_gnt = 1;
    checks++;
    if (done_cnt == 0) begin
      failures++;
      $display("FAIL done_timeout: got no done after %0d cycles, want done", n);
    end
  endtask
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({cmd_ready[k], busy[k], done[k], rd_req[k], cmp_valid[k]} !== 5'b10000) begin
        failures++;
        $display("FAIL reset_ctl[%0d]: got %b want 10000", k, {cmd_ready[k], busy[k], done[k], rd_req[k], cmp_valid[k]});
      end
      checks++;
      if ((rd_addr0[k] | rd_addr1[k] | cmp_addr[k] | 32'(cmp_start_idx[k])) !== 0 ||
          (cmp_vec0[k] | cmp_vec1[k]) !== 0 || {cmp_req_start[k], cmp_req_end[k], cmp_sew[k], cmp_opsel[k]} !== 0) begin
        failures++;
        $display("FAIL reset_data[%0d]: got addr %h vec %h want 0", k, rd_addr0[k] | cmp_addr[k], cmp_vec0[k]);
      end
    end
    rst = 1;
  endtask
  task automatic test_basic;
    run_cmd(0, 32'h10, 32'h20, 32'h30, 3'd0, 9'd16, 3'd3);
    checks++;
    if ({aq0[0], aq0[1], aq1[0], aq1[1]} !== {32'h10, 32'h11, 32'h20, 32'h21} || aq0.size() != 2) begin
      failures++;
      $display("FAIL basic_rd_addr: got %h n=%0d want 10,11,20,21", {aq0[0], aq0[1], aq1[0], aq1[1]}, aq0.size());
    end
    checks++;
    if (first_rd != acc_cyc || first_cmp != acc_cyc + 1) begin
      failures++;
      $display("FAIL basic_latency: got rd %0d cmp %0d want rd %0d cmp %0d", first_rd, first_cmp, acc_cyc, acc_cyc + 1);
    end
    checks++;
    if (bq.size() != 2 || {bq[0].idx, bq[0].first, bq[0].last, bq[0].addr} !== {8'd0, 1'b1, 1'b0, 32'h30} ||
        {bq[1].idx, bq[1].first, bq[1].last, bq[1].addr} !== {8'd8, 1'b0, 1'b1, 32'h30}) begin
      failures++;
      $display("FAIL basic_meta: got n=%0d idx %0d,%0d flags %b%b,%b%b want n=2 idx 0,8 flags 10,01",
               bq.size(), bq[0].idx, bq[1].idx, bq[0].first, bq[0].last, bq[1].first, bq[1].last);
    end
    checks++;
    if ({bq[0].v0, bq[0].v1, bq[1].v0, bq[1].v1} !== {f(32'h10), f(32'h20), f(32'h11), f(32'h21)}) begin
      failures++;
      $display("FAIL basic_data: got %h %h want %h %h", bq[0].v0, bq[1].v1, f(32'h10), f(32'h21));
    end
    checks++;
    if (done_cyc - last_cmp != 7) begin
      failures++;
      $display("FAIL basic_done_delay: got %0d want 7", done_cyc - last_cmp);
    end
    checks++;
    if (done[0] !== 1'b0 || cmd_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL basic_after_done: got done %b ready %b busy %b want 0 1 0", done[0], cmd_ready[0], busy[0]);
    end
  endtask
  task automatic test_sew64;
    run_cmd(0, 32'h100, 32'h200, 32'h40, 3'd3, 9'd3, 3'd5);
    checks++;
    if (bq.size() != 3) begin
      failures++;
      $display("FAIL sew64_beats: got %0d want 3", bq.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bq[i].idx, bq[i].first, bq[i].last, bq[i].addr, bq[i].sew, bq[i].op} !==
          {8'(i), i == 0, i == 2, 32'h40, 3'd3, 3'd5}) begin
        failures++;
        $display("FAIL sew64_meta[%0d]: got idx %0d f%b l%b addr %h sew %0d op %0d want idx %0d addr 40 sew 3 op 5",
                 i, bq[i].idx, bq[i].first, bq[i].last, bq[i].addr, bq[i].sew, bq[i].op, i);
      end
    end
  endtask
  task automatic test_vl72;
    run_cmd(0, 32'h50, 32'h60, 32'h70, 3'd0, 9'd72, 3'd0);
    checks++;
    if (bq.size() != 9 || aq0.size() != 9 || aq0[8] !== 32'h58) begin
      failures++;
      $display("FAIL vl72_beats: got %0d beats last rd %h want 9 beats last rd 58", bq.size(), aq0[8]);
    end
    checks++;
    if ({bq[7].idx, bq[7].last, bq[7].addr} !== {8'd56, 1'b0, 32'h70} ||
        {bq[8].idx, bq[8].last, bq[8].addr} !== {8'd0, 1'b1, 32'h71}) begin
      failures++;
      $display("FAIL vl72_wrap: got b7 %0d/%h b8 %0d/%h last %b want 56/70 0/71 last 1",
               bq[7].idx, bq[7].addr, bq[8].idx, bq[8].addr, bq[8].last);
    end
  endtask
  task automatic test_vl0;
    run_cmd(0, 32'h1, 32'h2, 32'h3, 3'd0, 9'd0, 3'd0);
    checks++;
    if (rdreq_cnt != 0 || bq.size() != 0) begin
      failures++;
      $display("FAIL vl0_activity: got rd_req %0d cmp %0d want 0 0", rdreq_cnt, bq.size());
    end
    checks++;
    if (done_cnt != 1 || done_cyc != acc_cyc || cmd_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL vl0_done: got cnt %0d at +%0d ready %b want 1 at +0 ready 1", done_cnt, done_cyc - acc_cyc, cmd_ready[0]);
    end
  endtask
  task automatic test_stall;
    int exp_c [4] = '{2, 5, 6, 7};
    gpat = 16'hFFF9;
    run_cmd(1, 32'h80, 32'h90, 32'hA0, 3'd0, 9'd32, 3'd1);
    gpat = 16'hFFFF;
    checks++;
    if ({alog[0], alog[1], alog[2], alog[3], alog[4]} !== {32'h80, 32'h81, 32'h81, 32'h81, 32'h82}) begin
      failures++;
      $display("FAIL stall_addr_hold: got %h want 80,81,81,81,82", {alog[0], alog[1], alog[2], alog[3], alog[4]});
    end
    checks++;
    if (bq.size() != 4 || aq0.size() != 4) begin
      failures++;
      $display("FAIL stall_beats: got cmp %0d grants %0d want 4 4", bq.size(), aq0.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bq[i].idx, bq[i].first, bq[i].last, bq[i].addr, bq[i].v0, bq[i].v1} !==
          {8'(8 * i), i == 0, i == 3, 32'hA0, f(32'h80 + 32'(i)), f(32'h90 + 32'(i))} || bq[i].c - acc_cyc != exp_c[i]) begin
        failures++;
        $display("FAIL stall_beat[%0d]: got idx %0d at +%0d v0 %h want idx %0d at +%0d v0 %h",
                 i, bq[i].idx, bq[i].c - acc_cyc, bq[i].v0, 8 * i, exp_c[i], f(32'h80 + 32'(i)));
      end
    end
    checks++;
    if (done_cyc - last_cmp != 7) begin
      failures++;
      $display("FAIL stall_done_delay: got %0d want 7", done_cyc - last_cmp);
    end
  endtask
  task automatic test_reset_mid;
    int bad = 0;
    int n = 0;
    sel = 0;
    while (!(cmd_ready[0] && cmd_ready[1]) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    cmd_vs2 = 32'hE0; cmd_vs1 = 32'hF0; cmd_vd = 32'h10; cmd_sew = 0; cmd_vl = 9'd64; cmd_opsel = 0;
    cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    checks++;
    if (busy[0] !== 1'b1 || rd_req[1] !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_setup: got busy %b rd_req %b want 1 1", busy[0], rd_req[1]);
    end
    rst = 0;
    @(posedge clk); #1;
    rst = 1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({cmd_ready[k], busy[k], done[k], rd_req[k], cmp_valid[k]} !== 5'b10000 ||
          (rd_addr0[k] | rd_addr1[k] | cmp_addr[k]) !== 0 || (cmp_vec0[k] | cmp_vec1[k]) !== 0) begin
        failures++;
        $display("FAIL rstmid_idle[%0d]: got ctl %b addr %h vec %h want 10000 0 0", k,
                 {cmd_ready[k], busy[k], done[k], rd_req[k], cmp_valid[k]}, rd_addr0[k] | cmp_addr[k], cmp_vec0[k] | cmp_vec1[k]);
      end
    end
    repeat (6) begin
      @(negedge clk);
      if (cmp_valid[0] || cmp_valid[1] || rd_req[0] || rd_req[1]) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rstmid_late_data: got %0d active cycles want 0", bad);
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_sew64;
    test_vl72;
    test_vl0;
    test_stall;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end
endmodule
